pipeline_stage_tx: RTL and testbench
====================================

// Module: pipeline_stage_tx
// PURPOSE
//   Sender end of the valid/stall/flush stage protocol: the producer that feeds one
//   client port (in_valid_N/in_data_N/in_stall_N/in_flush_N) of shared_resource_top.
//   Accepts words from local logic via a ready/valid source port and queues them in a
//   DEPTH-entry FIFO. Presents them one per cycle on a registered output, holds them
//   under stall, and issues flush pulses on request.
// PARAMETERS
//   DATA_W  32  width of src_data / out_data
//   DEPTH   4   FIFO entries; power of 2, >=2
//   CNT_W   16  width of tx_count
// PORTS
//   clk         in   1             clock; all state updates on posedge
//   reset       in   1             asynchronous, active-low reset
//   src_valid   in   1             local producer offers src_data
//   src_data    in   DATA_W        word offered
//   src_ready   out  1             word accepted this cycle when src_valid & src_ready
//   flush_req   in   1             request one flush of queued + in-flight work
//   out_valid   out  1             drives receiver in_valid
//   out_data    out  DATA_W        drives receiver in_data
//   out_flush   out  1             drives receiver in_flush; one-cycle pulse
//   in_stall    in   1             receiver backpressure (receiver out_stall)
//   fifo_level  out  $clog2(DEPTH)+1  entries held in FIFO, excluding output reg
//   tx_count    out  CNT_W         words transferred since reset/flush; wraps
// BEHAVIOUR
//   Reset (reset==0, async): FIFO empty, state IDLE.
//     out_valid=0, out_data=0, out_flush=0, tx_count=0, fifo_level=0, src_ready=0.
//   Transfer: a word leaves on any cycle with out_valid & !in_stall.
//     While in_stall & out_valid, out_valid and out_data must remain stable.
//   Output register, loaded at posedge when empty, or on a transfer that cycle:
//     - FIFO non-empty: load FIFO head, pop.
//     - Else src accepted that cycle: load src_data directly (bypass).
//       Latency src accept -> out_valid = 1 cycle.
//     - Else out_valid <= 0.
//   FIFO push: accepted src word that is not bypassed.
//     Simultaneous push+pop holds fifo_level constant.
//   src_ready = (fifo_level<DEPTH) & (state!=FLUSH) & !flush_req.
//     Combinational; never depends on in_stall directly.
//   FSM:
//     IDLE  -> SEND   when output register loads.
//     SEND  -> IDLE   on a transfer with nothing to reload.
//     any   -> FLUSH  on flush_req. Flush has priority over src accept and transfer.
//     FLUSH -> IDLE   after exactly one cycle.
//   FLUSH cycle: out_flush=1, out_valid=0, FIFO cleared, tx_count=0.
//     in_stall is ignored.
//   flush_req held high: FLUSH is re-entered each cycle, out_flush stays high,
//     src_ready stays 0.
//   tx_count increments per transfer; wraps 2^CNT_W-1 -> 0.
//   Full FIFO + stalled output: src_ready=0; no word dropped or overwritten.
//   Pointers wrap modulo DEPTH.
//   Reset mid-transfer: word discarded, outputs go to reset values immediately.
// STRUCTURE
//   pipe_pkg: DATA_W default, state enum {IDLE,SEND,FLUSH}, flush priority constants.
//   Sub-module tx_fifo (DATA_W, DEPTH): push/pop/clear, head, level, full/empty.
//     Registered storage, no output bypass.
//   Top: FSM, output register, bypass mux, counter.
// TESTING
//   1. Reset, src_valid=1 data=0xA5A5_0001, in_stall=0
//      -> next cycle out_valid=1, out_data=0xA5A5_0001; tx_count=1 after transfer.
//   2. in_stall=1, push 5 words 1..5 (DEPTH=4)
//      -> out holds word 1; fifo_level=4; src_ready=0 at word 6.
//      Release stall -> words 1..5 in order, one per cycle, none lost.
//   3. Stall toggled every other cycle over 20 words
//      -> out_data stable whenever stalled; received sequence equals sent sequence.
//   4. flush_req with 3 queued and out_valid=1 stalled
//      -> next cycle out_flush=1, out_valid=0, fifo_level=0, tx_count=0;
//         IDLE the cycle after.
//   5. flush_req and src_valid same cycle
//      -> src_ready=0, word not queued, out_flush pulse only.
//   6. reset asserted mid-stream, async to clk
//      -> out_valid/out_flush/fifo_level/tx_count = 0 immediately.
//      tx_count wrap with CNT_W=4: 16 transfers -> 0.

Source files
------------

// File: rtl/pipeline_stage_tx_pkg.sv
// Shared types for the stage-protocol sender: FSM states and width defaults.
package pipeline_stage_tx_pkg;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } tx_state_e;

    // Next state once any flush request has been ruled out.
    function automatic tx_state_e settle_state(input logic out_valid_next);
        return out_valid_next ? SEND : IDLE;
    endfunction
endpackage

// File: rtl/pipeline_stage_tx_if.sv
// Source (ready/valid) and receiver (valid/stall/flush) signals of the sender.
interface pipeline_stage_tx_if #(
    parameter int DATA_W = 32
);
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_flush;
    logic              in_stall;

    modport master (
        input  src_valid, src_data, in_stall,
        output src_ready, out_valid, out_data, out_flush
    );

    modport slave (
        output src_valid, src_data, in_stall,
        input  src_ready, out_valid, out_data, out_flush
    );
endinterface

// File: rtl/pipeline_stage_tx_fifo.sv
// Registered-storage FIFO with synchronous clear; head is the oldest entry, no bypass.
module pipeline_stage_tx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    input  logic                     clear,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       level_q, level_d;
    logic              push_ok, pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_q];
    assign level   = level_q;

    // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + AW'(1);
            if (pop_ok)  rd_d = rd_q + AW'(1);
            level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_q] <= wdata;
    end
endmodule

// File: rtl/pipeline_stage_tx.sv
// Stage-protocol sender: queues local words and presents them on a registered,
// stall-stable output; flush_req discards all queued and in-flight work.
module pipeline_stage_tx
    import pipeline_stage_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_stage_tx_if.master    bus,
    input  logic                   flush_req,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       tx_count
);
    tx_state_e         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_flush_q, out_flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              transfer, load, src_acc;
    logic              push, pop, clear, full, empty;
    logic [DATA_W-1:0] head;

    pipeline_stage_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .wdata (bus.src_data),
        .pop   (pop),
        .clear (clear),
        .head  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign bus.src_ready = reset & ~full & (state_q != FLUSH) & ~flush_req;
    assign transfer      = out_valid_q & ~bus.in_stall;
    assign load          = ~out_valid_q | transfer;
    assign src_acc       = bus.src_valid & bus.src_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flush_d = 1'b0;
        cnt_d       = cnt_q;
        push        = 1'b0;
        pop         = 1'b0;
        clear       = 1'b0;
        // Flush wins over both transfer and source accept; stall is irrelevant here.
        if (flush_req) begin
            state_d     = FLUSH;
            out_valid_d = 1'b0;
            out_flush_d = 1'b1;
            cnt_d       = '0;
            clear       = 1'b1;
        end else begin
            if (transfer) cnt_d = cnt_q + CNT_W'(1);
            if (load) begin
                if (!empty) begin
                    out_valid_d = 1'b1;
                    out_data_d  = head;
                    pop         = 1'b1;
                end else if (src_acc) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.src_data;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            push    = src_acc & ~(load & empty);
            state_d = settle_state(out_valid_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flush_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flush_q <= out_flush_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flush = out_flush_q;
    assign tx_count      = cnt_q;
endmodule

// File: tb/tb_pipeline_stage_tx.sv
// Scoreboard bench for pipeline_stage_tx: accepted words are queued, a negedge
// monitor pops them on each transfer and checks level/valid/flush/count every cycle.
module tb_pipeline_stage_tx;
    import pipeline_stage_tx_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_req = 1'b0;
    logic [2:0]       fifo_level;
    logic [CNT_W-1:0] tx_count;

    pipeline_stage_tx_if #(.DATA_W(DATA_W)) bus ();

    pipeline_stage_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .bus        (bus),
        .flush_req  (flush_req),
        .fifo_level (fifo_level),
        .tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0]      sb_q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_fl = 1'b0;
    logic             hold = 1'b0;
    logic [31:0]      hold_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares the current cycle, then applies what the
    // coming posedge will do to the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_cnt = '0;
            m_fl  = 1'b0;
            hold  = 1'b0;
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_out_flush", 32'(bus.out_flush), 0);
            chk("rst_fifo_level", 32'(fifo_level), 0);
            chk("rst_tx_count", 32'(tx_count), 0);
            chk("rst_src_ready", 32'(bus.src_ready), 0);
        end else begin
            automatic int  n   = sb_q.size();
            automatic int  lvl = (n > 0) ? n - 1 : 0;
            automatic logic rdy = !flush_req && !m_fl && (lvl < DEPTH);
            chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
            chk("fifo_level", 32'(fifo_level), 32'(lvl));
            chk("tx_count", 32'(tx_count), 32'(m_cnt));
            chk("out_flush", 32'(bus.out_flush), 32'(m_fl));
            chk("src_ready", 32'(bus.src_ready), 32'(rdy));
            if (hold) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_data", bus.out_data, hold_data);
            end
            if (flush_req) begin
                sb_q.delete();
                m_cnt = '0;
                m_fl  = 1'b1;
                hold  = 1'b0;
            end else begin
                m_fl = 1'b0;
                if (bus.out_valid && !bus.in_stall) begin
                    if (sb_q.size() == 0) chk("sb_underrun", 1, 0);
                    else chk("sb_data", bus.out_data, sb_q.pop_front());
                    m_cnt = m_cnt + 1'b1;
                end
                hold      = bus.out_valid && bus.in_stall;
                hold_data = bus.out_data;
                if (bus.src_valid && bus.src_ready) sb_q.push_back(bus.src_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // smode: 0 = no stall, 1 = stall toggles every cycle, 2 = stall held high
    task automatic send(input int n, input logic [31:0] base, input int smode);
        int i = 0;
        int cyc = 0;
        logic acc;
        while (i < n && cyc < 500) begin
            bus.src_valid = 1'b1;
            bus.src_data  = base + 32'(i);
            bus.in_stall  = (smode == 2) ? 1'b1 : (smode == 1) ? cyc[0] : 1'b0;
            @(negedge clk);
            acc = bus.src_ready;
            tick();
            if (acc) i++;
            cyc++;
        end
        bus.src_valid = 1'b0;
        if (i < n) chk("send_timeout", 32'(i), 32'(n));
    endtask

    task automatic drain();
        int c = 0;
        bus.in_stall = 1'b0;
        while (sb_q.size() != 0 && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.in_stall  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: single word, bypass latency one cycle
        bus.src_valid = 1'b1;
        bus.src_data  = 32'hA5A5_0001;
        tick();
        bus.src_valid = 1'b0;
        @(negedge clk);
        chk("t1_out_valid", 32'(bus.out_valid), 1);
        chk("t1_out_data", bus.out_data, 32'hA5A5_0001);
        tick();
        @(negedge clk);
        chk("t1_tx_count", 32'(tx_count), 1);
        tick();

        // 2: stalled output, FIFO fills, sixth word refused
        send(5, 32'd1, 2);
        bus.src_valid = 1'b1;
        bus.src_data  = 32'd6;
        @(negedge clk);
        chk("t2_src_ready", 32'(bus.src_ready), 0);
        chk("t2_fifo_level", 32'(fifo_level), 4);
        chk("t2_out_data", bus.out_data, 32'd1);
        tick();
        bus.src_valid = 1'b0;
        drain();

        // 3: stall toggling over 20 words
        send(20, 32'd100, 1);
        drain();

        // 4: flush with three queued and a stalled output word
        send(4, 32'd200, 2);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk("t4_out_flush", 32'(bus.out_flush), 1);
        chk("t4_out_valid", 32'(bus.out_valid), 0);
        chk("t4_fifo_level", 32'(fifo_level), 0);
        chk("t4_tx_count", 32'(tx_count), 0);
        tick();
        @(negedge clk);
        chk("t4_state_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t4_flush_pulse", 32'(bus.out_flush), 0);
        tick();
        bus.in_stall = 1'b0;

        // 5: flush and source offer in the same cycle
        bus.src_valid = 1'b1;
        bus.src_data  = 32'hDEAD_BEEF;
        flush_req     = 1'b1;
        @(negedge clk);
        chk("t5_src_ready", 32'(bus.src_ready), 0);
        tick();
        bus.src_valid = 1'b0;
        flush_req     = 1'b0;
        @(negedge clk);
        chk("t5_out_flush", 32'(bus.out_flush), 1);
        chk("t5_out_valid", 32'(bus.out_valid), 0);
        tick();
        @(negedge clk);
        chk("t5_no_word", 32'(bus.out_valid), 0);
        chk("t5_level", 32'(fifo_level), 0);
        tick();

        // 6: asynchronous reset mid-stream
        send(3, 32'd300, 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_out_flush", 32'(bus.out_flush), 0);
        chk("t6_fifo_level", 32'(fifo_level), 0);
        chk("t6_tx_count", 32'(tx_count), 0);
        repeat (2) tick();
        bus.in_stall = 1'b0;
        rst_n = 1'b1;
        tick();

        // tx_count wrap at CNT_W=4
        send(16, 32'd400, 0);
        drain();
        @(negedge clk);
        chk("wrap_tx_count", 32'(tx_count), 0);
        tick();
        send(1, 32'd500, 0);
        drain();
        @(negedge clk);
        chk("wrap_tx_count_1", 32'(tx_count), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
